// File: rtl/match_frame_reporter.sv
// Per-frame match reporter: collapses the comparator's sticky match into one report per frame
// on a valid/ready handshake. Optional MATCH_TIMESTAMP_EN adds a free-running timestamp and report_ts.
module match_frame_reporter #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16,
  parameter int TOT_W  = 32,
  parameter int TS_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              word_valid,
  input  logic              frame_sop,
  input  logic              frame_eop,
  input  logic              match,
  input  logic [DATA_W-1:0] data_in,
  output logic              cmp_clear,
  output logic              report_valid,
  input  logic              report_ready,
  output logic              report_hit,
  output logic [CNT_W-1:0]  report_words,
  output logic [CNT_W-1:0]  report_first_idx,
  output logic [DATA_W-1:0] report_first_word,
  output logic [TOT_W-1:0]  total_hits,
  output logic [TOT_W-1:0]  drop_cnt,
  output logic [TOT_W-1:0]  err_cnt
`ifdef MATCH_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0]   report_ts
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FRAME,
    S_FLUSH
  } state_t;

  state_t state_q, state_d;

  logic              cmp_clear_q, cmp_clear_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              fhit_q, fhit_d;
  logic [CNT_W-1:0]  fidx_q, fidx_d;
  logic [DATA_W-1:0] fword_q, fword_d;

  logic              rv_q, rv_d;
  logic              rhit_q, rhit_d;
  logic [CNT_W-1:0]  rwords_q, rwords_d;
  logic [CNT_W-1:0]  ridx_q, ridx_d;
  logic [DATA_W-1:0] rword_q, rword_d;

  logic [TOT_W-1:0]  hits_q, hits_d;
  logic [TOT_W-1:0]  drop_q, drop_d;
  logic [TOT_W-1:0]  err_q, err_d;

`ifdef MATCH_TIMESTAMP_EN
  logic [TS_W-1:0]   ts_q, ts_d;
  logic [TS_W-1:0]   rts_q, rts_d;
`endif

  logic              start_word;
  logic              cont_word;
  logic [CNT_W-1:0]  cur_cnt;
  logic              base_hit;
  logic [CNT_W-1:0]  base_idx;
  logic [DATA_W-1:0] base_word;

  function automatic logic [CNT_W-1:0] inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [TOT_W-1:0] inc_tot(input logic [TOT_W-1:0] v);
    return (&v) ? v : v + TOT_W'(1);
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fhit_d     = fhit_q;
    fidx_d     = fidx_q;
    fword_d    = fword_q;
    rv_d       = rv_q & ~report_ready;
    rhit_d     = rhit_q;
    rwords_d   = rwords_q;
    ridx_d     = ridx_q;
    rword_d    = rword_q;
    hits_d     = hits_q;
    drop_d     = drop_q;
    err_d      = err_q;
    start_word = 1'b0;
    cont_word  = 1'b0;
`ifdef MATCH_TIMESTAMP_EN
    ts_d       = ts_q + TS_W'(1);
    rts_d      = rts_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (word_valid) begin
          if (frame_sop) begin
            start_word = 1'b1;
            state_d    = frame_eop ? S_FLUSH : S_FRAME;
          end else begin
            err_d = inc_tot(err_q);
          end
        end
      end
      S_FRAME: begin
        if (word_valid) begin
          if (frame_sop) begin
            // abandon the current frame and restart with this word as word 1
            err_d      = inc_tot(err_q);
            start_word = 1'b1;
            state_d    = frame_eop ? S_FLUSH : S_FRAME;
          end else begin
            cont_word = 1'b1;
            if (frame_eop) state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        state_d = S_IDLE;
        if (word_valid) err_d = inc_tot(err_q);
      end
      default: state_d = S_IDLE;
    endcase

    cur_cnt   = start_word ? CNT_W'(1) : inc_cnt(cnt_q);
    base_hit  = start_word ? 1'b0 : fhit_q;
    base_idx  = start_word ? '0 : fidx_q;
    base_word = start_word ? '0 : fword_q;

    if (start_word || cont_word) begin
      cnt_d   = cur_cnt;
      fhit_d  = base_hit;
      fidx_d  = base_idx;
      fword_d = base_word;
      if (match && !base_hit) begin
        fhit_d  = 1'b1;
        fidx_d  = cur_cnt;
        fword_d = data_in;
      end
      // report fields include the eop word's own contribution
      if (frame_eop) begin
        if (fhit_d) hits_d = inc_tot(hits_q);
        if (!rv_q || report_ready) begin
          rv_d     = 1'b1;
          rhit_d   = fhit_d;
          rwords_d = cnt_d;
          ridx_d   = fidx_d;
          rword_d  = fword_d;
`ifdef MATCH_TIMESTAMP_EN
          rts_d    = ts_q;
`endif
        end else begin
          drop_d = inc_tot(drop_q);
        end
      end
    end

    cmp_clear_d = (state_d == S_FLUSH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cmp_clear_q <= 1'b0;
      cnt_q       <= '0;
      fhit_q      <= 1'b0;
      fidx_q      <= '0;
      fword_q     <= '0;
      rv_q        <= 1'b0;
      rhit_q      <= 1'b0;
      rwords_q    <= '0;
      ridx_q      <= '0;
      rword_q     <= '0;
      hits_q      <= '0;
      drop_q      <= '0;
      err_q       <= '0;
`ifdef MATCH_TIMESTAMP_EN
      ts_q        <= '0;
      rts_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cmp_clear_q <= cmp_clear_d;
      cnt_q       <= cnt_d;
      fhit_q      <= fhit_d;
      fidx_q      <= fidx_d;
      fword_q     <= fword_d;
      rv_q        <= rv_d;
      rhit_q      <= rhit_d;
      rwords_q    <= rwords_d;
      ridx_q      <= ridx_d;
      rword_q     <= rword_d;
      hits_q      <= hits_d;
      drop_q      <= drop_d;
      err_q       <= err_d;
`ifdef MATCH_TIMESTAMP_EN
      ts_q        <= ts_d;
      rts_q       <= rts_d;
`endif
    end
  end

  assign cmp_clear         = cmp_clear_q;
  assign report_valid      = rv_q;
  assign report_hit        = rhit_q;
  assign report_words      = rwords_q;
  assign report_first_idx  = ridx_q;
  assign report_first_word = rword_q;
  assign total_hits        = hits_q;
  assign drop_cnt          = drop_q;
  assign err_cnt           = err_q;
`ifdef MATCH_TIMESTAMP_EN
  assign report_ts         = rts_q;
`endif

endmodule

// File: tb/tb_match_frame_reporter.sv
// Directed bench for match_frame_reporter: vector table plus hand sequences for back-pressure,
// mid-frame reset and (with MATCH_TIMESTAMP_EN) the report timestamp.
module tb_match_frame_reporter;

  logic        clk = 1'b0;
  logic        rst;
  logic        word_valid, frame_sop, frame_eop, match;
  logic [31:0] data_in;
  logic        cmp_clear, report_valid, report_ready, report_hit;
  logic [15:0] report_words, report_first_idx;
  logic [31:0] report_first_word, total_hits, drop_cnt, err_cnt;
`ifdef MATCH_TIMESTAMP_EN
  logic [31:0] report_ts;
`endif

  always #5 clk = ~clk;

  match_frame_reporter #(.DATA_W(32), .CNT_W(16), .TOT_W(32), .TS_W(32)) dut (
    .clk(clk), .rst(rst), .word_valid(word_valid), .frame_sop(frame_sop),
    .frame_eop(frame_eop), .match(match), .data_in(data_in), .cmp_clear(cmp_clear),
    .report_valid(report_valid), .report_ready(report_ready), .report_hit(report_hit),
    .report_words(report_words), .report_first_idx(report_first_idx),
    .report_first_word(report_first_word), .total_hits(total_hits),
    .drop_cnt(drop_cnt), .err_cnt(err_cnt)
`ifdef MATCH_TIMESTAMP_EN
    , .report_ts(report_ts)
`endif
  );

  typedef struct {
    logic        wv, sop, eop, m, rdy;
    logic [31:0] d;
    logic        cc, rv, hit;
    logic [15:0] words, idx;
    logic [31:0] fw, th, dc, ec;
  } vec_t;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic wv, sop, eop, m, rdy, input logic [31:0] d);
    word_valid = wv; frame_sop = sop; frame_eop = eop; match = m;
    report_ready = rdy; data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic cc, rv, hit, input logic [15:0] w, ix,
                         input logic [31:0] fw, th, dc, ec);
    chk({tag, ".cmp_clear"}, 32'(cmp_clear), 32'(cc));
    chk({tag, ".valid"}, 32'(report_valid), 32'(rv));
    chk({tag, ".hit"}, 32'(report_hit), 32'(hit));
    chk({tag, ".words"}, 32'(report_words), 32'(w));
    chk({tag, ".first_idx"}, 32'(report_first_idx), 32'(ix));
    chk({tag, ".first_word"}, report_first_word, fw);
    chk({tag, ".total_hits"}, total_hits, th);
    chk({tag, ".drop_cnt"}, drop_cnt, dc);
    chk({tag, ".err_cnt"}, err_cnt, ec);
  endtask

  vec_t vt[20];

  initial begin
    //        wv sop eop m rdy d               cc rv hit words idx fw            th dc ec
    vt[0]  = '{1, 1, 0, 0, 1, 32'h11,          0, 0, 0, 0, 0, 32'h0,         0, 0, 0};
    vt[1]  = '{1, 0, 0, 1, 1, 32'hA1B2C3D4,    0, 0, 0, 0, 0, 32'h0,         0, 0, 0};
    vt[2]  = '{1, 0, 1, 1, 1, 32'h55,          1, 1, 1, 3, 2, 32'hA1B2C3D4,  1, 0, 0};
    vt[3]  = '{0, 0, 0, 1, 1, 32'h0,           0, 0, 1, 3, 2, 32'hA1B2C3D4,  1, 0, 0};
    vt[4]  = '{1, 1, 1, 0, 1, 32'h77,          1, 1, 0, 1, 0, 32'h0,         1, 0, 0};
    vt[5]  = '{0, 0, 0, 0, 1, 32'h0,           0, 0, 0, 1, 0, 32'h0,         1, 0, 0};
    vt[6]  = '{1, 1, 0, 0, 1, 32'h1,           0, 0, 0, 1, 0, 32'h0,         1, 0, 0};
    vt[7]  = '{1, 0, 0, 0, 1, 32'h2,           0, 0, 0, 1, 0, 32'h0,         1, 0, 0};
    vt[8]  = '{1, 1, 0, 0, 1, 32'h3,           0, 0, 0, 1, 0, 32'h0,         1, 0, 1};
    vt[9]  = '{1, 0, 1, 0, 1, 32'h4,           1, 1, 0, 2, 0, 32'h0,         1, 0, 1};
    vt[10] = '{0, 0, 0, 0, 1, 32'h0,           0, 0, 0, 2, 0, 32'h0,         1, 0, 1};
    vt[11] = '{1, 0, 0, 0, 1, 32'h5,           0, 0, 0, 2, 0, 32'h0,         1, 0, 2};
    vt[12] = '{1, 1, 1, 1, 1, 32'hCAFEF00D,    1, 1, 1, 1, 1, 32'hCAFEF00D,  2, 0, 2};
    vt[13] = '{1, 1, 0, 0, 1, 32'h6,           0, 0, 1, 1, 1, 32'hCAFEF00D,  2, 0, 3};
    vt[14] = '{1, 0, 1, 0, 1, 32'h7,           0, 0, 1, 1, 1, 32'hCAFEF00D,  2, 0, 4};
    vt[15] = '{1, 1, 0, 0, 1, 32'h9,           0, 0, 1, 1, 1, 32'hCAFEF00D,  2, 0, 4};
    vt[16] = '{0, 0, 0, 1, 1, 32'hDEAD,        0, 0, 1, 1, 1, 32'hCAFEF00D,  2, 0, 4};
    vt[17] = '{1, 0, 0, 1, 1, 32'hBEEF,        0, 0, 1, 1, 1, 32'hCAFEF00D,  2, 0, 4};
    vt[18] = '{1, 0, 1, 1, 1, 32'h0,           1, 1, 1, 3, 2, 32'hBEEF,      3, 0, 4};
    vt[19] = '{0, 0, 0, 0, 1, 32'h0,           0, 0, 1, 3, 2, 32'hBEEF,      3, 0, 4};

    rst = 1'b1;
    word_valid = 0; frame_sop = 0; frame_eop = 0; match = 0; report_ready = 0; data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      drive(vt[i].wv, vt[i].sop, vt[i].eop, vt[i].m, vt[i].rdy, vt[i].d);
      chk_all($sformatf("vec%0d", i), vt[i].cc, vt[i].rv, vt[i].hit, vt[i].words,
              vt[i].idx, vt[i].fw, vt[i].th, vt[i].dc, vt[i].ec);
    end

    // back-pressure: second report dropped while first is held
    drive(1, 1, 0, 0, 0, 32'h1);
    drive(1, 0, 1, 0, 0, 32'h2);
    chk_all("bp_first", 1, 1, 0, 2, 0, 0, 3, 0, 4);
    drive(0, 0, 0, 0, 0, 32'h0);
    chk_all("bp_hold", 0, 1, 0, 2, 0, 0, 3, 0, 4);
    drive(1, 1, 1, 1, 0, 32'hABCD);
    chk_all("bp_drop", 1, 1, 0, 2, 0, 0, 4, 1, 4);
    drive(0, 0, 0, 0, 1, 32'h0);
    chk_all("bp_accept", 0, 0, 0, 2, 0, 0, 4, 1, 4);

    // reset in the middle of a frame: everything cleared, no clear pulse
    drive(1, 1, 0, 1, 0, 32'h1234);
    drive(1, 0, 0, 0, 0, 32'h0);
    rst = 1'b1;
    drive(1, 0, 1, 0, 0, 32'h0);
    chk_all("midrst", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    drive(0, 0, 0, 0, 1, 32'h0);
    chk_all("post_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);

`ifdef MATCH_TIMESTAMP_EN
    // timestamp advanced once above; reset again so the eop lands on count 37
    rst = 1'b1;
    drive(0, 0, 0, 0, 1, 32'h0);
    rst = 1'b0;
    repeat (37) drive(0, 0, 0, 0, 1, 32'h0);
    drive(1, 1, 1, 0, 1, 32'h0);
    chk("ts", report_ts, 32'd37);
    chk("ts.valid", 32'(report_valid), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
